writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_if.sv | 29 ++
 rtl/writeback_stage.sv | 99 +++++++++
 tb/tb_writeback_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// MEM->WB handshake bundle: MEM-stage instruction fields in, register-file/forwarding/retire outputs back.
interface writeback_stage_if #(parameter int XLEN = 64);
   logic            mem_valid;
   logic            mem_reg_write;
   logic [4:0]      mem_rd_addr;
   logic [1:0]      mem_wb_sel;
   logic [XLEN-1:0] mem_alu_result;
   logic [XLEN-1:0] mem_load_data;
   logic [XLEN-1:0] mem_pc_plus4;
   logic [2:0]      mem_funct3;
   logic            stall;
   logic            flush;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            reg_write;
   logic            fwd_valid;
   logic [XLEN-1:0] instret;

   modport master (
      output mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel, mem_alu_result,
             mem_load_data, mem_pc_plus4, mem_funct3, stall, flush,
      input  rd_addr, rd_data, reg_write, fwd_valid, instret
   );
   modport slave (
      input  mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel, mem_alu_result,
             mem_load_data, mem_pc_plus4, mem_funct3, stall, flush,
      output rd_addr, rd_data, reg_write, fwd_valid, instret
   );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: result select, load extraction/extension, registered RF write port and retire counter.
module writeback_stage #(
   parameter int XLEN = 64
) (
   input  logic              clk,
   input  logic              rst,
   writeback_stage_if.slave  wb
);

   logic [4:0]      rd_addr_q,   rd_addr_d;
   logic [XLEN-1:0] rd_data_q,   rd_data_d;
   logic            reg_write_q, reg_write_d;
   logic [XLEN-1:0] instret_q,   instret_d;

   logic [63:0]     ld64, ext64;
   logic [XLEN-1:0] ext_x, wb_data;
   logic [2:0]      off;
   logic [7:0]      ld_b;
   logic [15:0]     ld_h;
   logic [31:0]     ld_w;

   // Extraction always works on a 64-bit doubleword view of the memory word.
   if (XLEN == 64) begin : g_eq
      assign ld64  = wb.mem_load_data;
      assign ext_x = ext64;
   end else if (XLEN > 64) begin : g_gt
      assign ld64  = wb.mem_load_data[63:0];
      assign ext_x = {{(XLEN-64){1'b0}}, ext64};
   end else begin : g_lt
      assign ld64  = {{(64-XLEN){1'b0}}, wb.mem_load_data};
      assign ext_x = ext64[XLEN-1:0];
   end

   always_comb begin
      off  = wb.mem_alu_result[2:0];
      ld_b = ld64[{off, 3'b000} +: 8];
      ld_h = ld64[{off[2:1], 4'b0000} +: 16];
      ld_w = ld64[{off[2], 5'b00000} +: 32];
      case (wb.mem_funct3)
         3'b000:  ext64 = {{56{ld_b[7]}}, ld_b};
         3'b001:  ext64 = {{48{ld_h[15]}}, ld_h};
         3'b010:  ext64 = {{32{ld_w[31]}}, ld_w};
         3'b011:  ext64 = ld64;
         3'b100:  ext64 = {56'd0, ld_b};
         3'b101:  ext64 = {48'd0, ld_h};
         3'b110:  ext64 = {32'd0, ld_w};
         default: ext64 = 64'd0;
      endcase
   end

   always_comb begin
      case (wb.mem_wb_sel)
         2'b00:   wb_data = wb.mem_alu_result;
         2'b01:   wb_data = ext_x;
         2'b10:   wb_data = wb.mem_pc_plus4;
         default: wb_data = '0;
      endcase
   end

   // flush > stall > capture > bubble; a stall holds the write port but never repeats the write.
   always_comb begin
      rd_addr_d   = '0;
      rd_data_d   = '0;
      reg_write_d = 1'b0;
      instret_d   = instret_q;
      if (wb.flush) begin
         rd_addr_d = '0;
      end else if (wb.stall) begin
         rd_addr_d = rd_addr_q;
         rd_data_d = rd_data_q;
      end else if (wb.mem_valid) begin
         rd_addr_d   = wb.mem_rd_addr;
         rd_data_d   = wb_data;
         reg_write_d = wb.mem_reg_write && (wb.mem_rd_addr != 5'd0);
         instret_d   = instret_q + {{(XLEN-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr_q   <= '0;
         rd_data_q   <= '0;
         reg_write_q <= 1'b0;
         instret_q   <= '0;
      end else begin
         rd_addr_q   <= rd_addr_d;
         rd_data_q   <= rd_data_d;
         reg_write_q <= reg_write_d;
         instret_q   <= instret_d;
      end
   end

   assign wb.rd_addr   = rd_addr_q;
   assign wb.rd_data   = rd_data_q;
   assign wb.reg_write = reg_write_q;
   assign wb.fwd_valid = reg_write_q;
   assign wb.instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a 64-bit instance for datapath checks, a 4-bit one for instret wrap.
module tb_writeback_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   logic [63:0] ir_exp = 64'd0;
   localparam logic [63:0] LD = 64'h80FF_7F01_8002_00FF;
   localparam logic [63:0] PC = 64'h0000_0000_1000_0004;

   writeback_stage_if #(.XLEN(64)) mif();
   writeback_stage_if #(.XLEN(4))  sif();

   writeback_stage #(.XLEN(64)) dut   (.clk(clk), .rst(rst), .wb(mif));
   writeback_stage #(.XLEN(4))  dut_s (.clk(clk), .rst(rst), .wb(sif));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [63:0] alu, input logic [2:0] f3, input logic st, input logic fl);
      mif.mem_valid      = v;
      mif.mem_reg_write  = rw;
      mif.mem_rd_addr    = rd;
      mif.mem_wb_sel     = sel;
      mif.mem_alu_result = alu;
      mif.mem_load_data  = LD;
      mif.mem_pc_plus4   = PC;
      mif.mem_funct3     = f3;
      mif.stall          = st;
      mif.flush          = fl;
      if (v && !st && !fl) ir_exp = ir_exp + 64'd1;
   endtask

   task automatic load(input logic [2:0] off, input logic [2:0] f3, input logic [63:0] exp, input string tag);
      drv(1, 1, 5'd9, 2'b01, {61'd0, off}, f3, 0, 0);
      @(negedge clk);
      chk(tag, mif.rd_data, exp);
   endtask

   initial begin
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      ir_exp = 0;
      sif.mem_valid = 0; sif.mem_reg_write = 0; sif.mem_rd_addr = 0; sif.mem_wb_sel = 0;
      sif.mem_alu_result = 0; sif.mem_load_data = 0; sif.mem_pc_plus4 = 0; sif.mem_funct3 = 0;
      sif.stall = 0; sif.flush = 0;

      #1 rst = 1'b0;
      #1;
      chk("rst_rd_addr", {59'd0, mif.rd_addr}, 0);
      chk("rst_rd_data", mif.rd_data, 0);
      chk("rst_reg_write", {63'd0, mif.reg_write}, 0);
      chk("rst_fwd_valid", {63'd0, mif.fwd_valid}, 0);
      chk("rst_instret", mif.instret, 0);

      // First capture at the first edge after release
      @(negedge clk);
      rst = 1'b1;
      drv(1, 1, 5'd7, 2'b00, 64'h1234, 3'b000, 0, 0);
      @(negedge clk);
      chk("alu_reg_write", {63'd0, mif.reg_write}, 1);
      chk("alu_fwd_valid", {63'd0, mif.fwd_valid}, 1);
      chk("alu_rd_addr", {59'd0, mif.rd_addr}, 7);
      chk("alu_rd_data", mif.rd_data, 64'h1234);
      chk("alu_instret", mif.instret, 1);

      load(3'd0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, "lb_off0");
      load(3'd0, 3'b100, 64'h0000_0000_0000_00FF, "lbu_off0");
      load(3'd2, 3'b000, 64'h0000_0000_0000_0002, "lb_off2");
      load(3'd6, 3'b001, 64'hFFFF_FFFF_FFFF_80FF, "lh_off6");
      load(3'd2, 3'b101, 64'h0000_0000_0000_8002, "lhu_off2");
      load(3'd3, 3'b001, 64'hFFFF_FFFF_FFFF_8002, "lh_misalign3");
      load(3'd4, 3'b010, 64'hFFFF_FFFF_80FF_7F01, "lw_off4");
      load(3'd4, 3'b110, 64'h0000_0000_80FF_7F01, "lwu_off4");
      load(3'd5, 3'b010, 64'hFFFF_FFFF_80FF_7F01, "lw_misalign5");
      load(3'd0, 3'b110, 64'h0000_0000_8002_00FF, "lwu_off0");
      load(3'd3, 3'b011, LD, "ld_full");
      load(3'd0, 3'b111, 64'd0, "f3_111_zero");
      chk("load_instret", mif.instret, ir_exp);

      drv(1, 1, 5'd1, 2'b10, 64'hDEAD, 3'b000, 0, 0);
      @(negedge clk);
      chk("sel_pc4", mif.rd_data, PC);
      drv(1, 1, 5'd1, 2'b11, 64'hDEAD, 3'b000, 0, 0);
      @(negedge clk);
      chk("sel_rsvd", mif.rd_data, 0);

      // x0 destination and non-writing instruction still retire
      drv(1, 1, 5'd0, 2'b00, 64'h55, 3'b000, 0, 0);
      @(negedge clk);
      chk("x0_reg_write", {63'd0, mif.reg_write}, 0);
      chk("x0_fwd_valid", {63'd0, mif.fwd_valid}, 0);
      chk("x0_instret", mif.instret, ir_exp);
      drv(1, 0, 5'd5, 2'b00, 64'h66, 3'b000, 0, 0);
      @(negedge clk);
      chk("st_reg_write", {63'd0, mif.reg_write}, 0);
      chk("st_rd_addr", {59'd0, mif.rd_addr}, 5);
      chk("st_instret", mif.instret, 17);

      drv(1, 1, 5'd3, 2'b00, 64'hA, 3'b000, 0, 0);
      @(negedge clk);
      chk("pre_stall_rw", {63'd0, mif.reg_write}, 1);
      drv(1, 1, 5'd4, 2'b00, 64'hB, 3'b000, 1, 0);
      @(negedge clk);
      chk("stall_reg_write", {63'd0, mif.reg_write}, 0);
      chk("stall_fwd_valid", {63'd0, mif.fwd_valid}, 0);
      chk("stall_rd_addr", {59'd0, mif.rd_addr}, 3);
      chk("stall_rd_data", mif.rd_data, 64'hA);
      chk("stall_instret", mif.instret, 18);
      drv(1, 1, 5'd4, 2'b00, 64'hB, 3'b000, 1, 1);
      @(negedge clk);
      chk("flush_rd_addr", {59'd0, mif.rd_addr}, 0);
      chk("flush_rd_data", mif.rd_data, 0);
      chk("flush_reg_write", {63'd0, mif.reg_write}, 0);
      chk("flush_instret", mif.instret, 18);

      drv(1, 1, 5'd8, 2'b00, 64'hC, 3'b000, 0, 0);
      @(negedge clk);
      drv(0, 1, 5'd9, 2'b00, 64'hD, 3'b000, 0, 0);
      @(negedge clk);
      chk("bubble_rd_addr", {59'd0, mif.rd_addr}, 0);
      chk("bubble_rd_data", mif.rd_data, 0);
      chk("bubble_reg_write", {63'd0, mif.reg_write}, 0);
      chk("bubble_instret", mif.instret, 19);

      // Reset between edges must clear outputs before any clock edge
      drv(1, 1, 5'd12, 2'b00, 64'hF00D, 3'b000, 0, 0);
      @(negedge clk);
      chk("pre_rst_rw", {63'd0, mif.reg_write}, 1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_rw", {63'd0, mif.reg_write}, 0);
      chk("async_rst_rd_addr", {59'd0, mif.rd_addr}, 0);
      chk("async_rst_rd_data", mif.rd_data, 0);
      chk("async_rst_instret", mif.instret, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      ir_exp = 0;

      // instret wrap on the narrow instance
      sif.mem_valid = 1; sif.mem_reg_write = 1; sif.mem_rd_addr = 5'd2; sif.mem_alu_result = 4'h5;
      repeat (15) @(negedge clk);
      chk("s_rd_data", {60'd0, sif.rd_data}, 5);
      chk("s_instret_max", {60'd0, sif.instret}, 64'hF);
      @(negedge clk);
      chk("s_instret_wrap", {60'd0, sif.instret}, 0);
      sif.mem_valid = 0;
      @(negedge clk);
      chk("s_instret_hold", {60'd0, sif.instret}, 0);
      chk("main_idle_instret", mif.instret, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
